// File: rtl/imm_extend_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : imm_extend_arbiter
// Brief   : Round-robin shared 16->32 immediate extender (SEXT/ZEXT/UPPER/
//           branch offset). It registers the result and presents it on a
//           valid/ready output tagged with the requester ID. A wrapping
//           transfer counter is kept for debug.
// Revision: 1.0 - initial release
// ============================================================================
module imm_extend_arbiter #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int N_REQ = 2,
  parameter int ID_W  = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*IN_W-1:0]   req_imm,
  input  logic [N_REQ*2-1:0]      req_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_data,
  output logic [ID_W-1:0]         out_id,
  output logic [15:0]             xfer_cnt
);

  localparam int       c_PAD_W     = OUT_W - IN_W;
  localparam logic [1:0] c_MODE_SEXT  = 2'b00;
  localparam logic [1:0] c_MODE_ZEXT  = 2'b01;
  localparam logic [1:0] c_MODE_UPPER = 2'b10;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ID_W-1:0]   r_rr_ptr;
  logic              w_drain;
  logic              w_can_accept;
  logic              w_found;
  logic [ID_W-1:0]   w_gnt_idx;
  logic              w_accept;
  logic [IN_W-1:0]   w_sel_imm;
  logic [1:0]        w_sel_mode;
  logic [OUT_W-1:0]  w_sext;
  logic [OUT_W-1:0]  w_ext;

  assign out_valid    = (r_state == ST_FULL);
  assign w_drain      = out_valid && out_ready;
  // Gating with rst_n keeps every req_ready low while reset is held.
  assign w_can_accept = rst_n && ((r_state == ST_EMPTY) || w_drain);
  assign w_accept     = w_can_accept && w_found;

  // Find the first valid requester at or above rr_ptr, wrapping around.
  always_comb begin
    int v_idx;
    w_found   = 1'b0;
    w_gnt_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      v_idx = (int'(r_rr_ptr) + k) % N_REQ;
      if (!w_found && req_valid[v_idx]) begin
        w_found   = 1'b1;
        w_gnt_idx = ID_W'(v_idx);
      end
    end
  end

  // One-hot ready for the granted lane only, during the accepting cycle.
  always_comb begin
    req_ready = '0;
    if (w_accept) begin
      req_ready[w_gnt_idx] = 1'b1;
    end
  end

  // Only the granted lane reaches the extender, so idle lanes cannot leak in.
  assign w_sel_imm  = req_imm[int'(w_gnt_idx)*IN_W +: IN_W];
  assign w_sel_mode = req_mode[int'(w_gnt_idx)*2 +: 2];
  assign w_sext     = {{c_PAD_W{w_sel_imm[IN_W-1]}}, w_sel_imm};

  // Extension mode decode; the branch offset is the sign extension scaled by 4.
  always_comb begin
    w_ext = w_sext;
    case (w_sel_mode)
      c_MODE_SEXT:  w_ext = w_sext;
      c_MODE_ZEXT:  w_ext = {{c_PAD_W{1'b0}}, w_sel_imm};
      c_MODE_UPPER: w_ext = {w_sel_imm, {c_PAD_W{1'b0}}};
      default:      w_ext = {w_sext[OUT_W-3:0], 2'b00};
    endcase
  end

  // Output-register occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: a new accept keeps/turns FULL, a drain alone empties.
  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      w_state_nxt = ST_FULL;
    end else if (w_drain) begin
      w_state_nxt = ST_EMPTY;
    end
  end

  // Result register, requester tag and round-robin pointer load on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_id   <= '0;
      r_rr_ptr <= '0;
    end else if (w_accept) begin
      out_data <= w_ext;
      out_id   <= w_gnt_idx;
      r_rr_ptr <= (w_gnt_idx == ID_W'(N_REQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);
    end
  end

  // Debug count of completed output handshakes, wrapping at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt <= '0;
    end else if (w_drain) begin
      xfer_cnt <= xfer_cnt + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imm_extend_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_imm_extend_arbiter
// Brief   : Directed self-checking bench for imm_extend_arbiter (N_REQ=2).
// Revision: 1.0 - initial release
// ============================================================================
module tb_imm_extend_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_imm;
  logic [3:0]  req_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [0:0]  out_id;
  logic [15:0] xfer_cnt;

  int total;
  int bad;

  imm_extend_arbiter #(
    .IN_W  (16),
    .OUT_W (32),
    .N_REQ (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_imm   (req_imm),
    .req_mode  (req_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .xfer_cnt  (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_data;
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_imm   = 32'h0;
    req_mode  = 4'h0;
    out_ready = 1'b1;

    // Reset state, with requests present to show ready stays low.
    repeat (2) step();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_id", {31'd0, out_id}, 32'd0);
    check("rst_cnt", {16'd0, xfer_cnt}, 32'd0);
    check("rst_ready", {30'd0, req_ready}, 32'd0);
    req_valid = 2'b00;
    #2 rst_n = 1'b1;
    step();

    // Requester 0, SEXT of a negative immediate.
    req_valid = 2'b01;
    req_imm   = {16'h0000, 16'hC7EA};
    req_mode  = 4'b0000;
    #1;
    check("sext_ready", {30'd0, req_ready}, 32'd1);
    step();
    check("sext_valid", {31'd0, out_valid}, 32'd1);
    check("sext_data", out_data, 32'hFFFFC7EA);
    check("sext_id", {31'd0, out_id}, 32'd0);
    check("sext_cnt", {16'd0, xfer_cnt}, 32'd0);

    // Requester 1, modes ZEXT / UPPER / BOFF back-to-back, then positive SEXT.
    req_valid = 2'b10;
    req_imm   = {16'hC7EA, 16'h0000};
    req_mode  = 4'b0100;
    #1;
    check("zext_ready", {30'd0, req_ready}, 32'd2);
    step();
    check("zext_data", out_data, 32'h0000C7EA);
    check("zext_id", {31'd0, out_id}, 32'd1);
    check("cnt_after_1", {16'd0, xfer_cnt}, 32'd1);
    req_mode = 4'b1000;
    step();
    check("upper_data", out_data, 32'hC7EA0000);
    check("upper_valid", {31'd0, out_valid}, 32'd1);
    req_mode = 4'b1100;
    step();
    check("boff_data", out_data, 32'hFFFF1FA8);
    check("boff_id", {31'd0, out_id}, 32'd1);
    req_imm  = {16'h1234, 16'h0000};
    req_mode = 4'b0000;
    step();
    check("pos_sext_data", out_data, 32'h00001234);
    check("cnt_after_4", {16'd0, xfer_cnt}, 32'd4);

    // Both requesting continuously: grants alternate starting at 0.
    req_valid = 2'b11;
    req_imm   = {16'h8000, 16'h0001};
    req_mode  = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_ready", {30'd0, req_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
      step();
      exp_data = (i % 2 == 0) ? 32'h00000001 : 32'hFFFF8000;
      check("rr_data", out_data, exp_data);
      check("rr_id", {31'd0, out_id}, 32'(i % 2));
    end
    check("cnt_after_8", {16'd0, xfer_cnt}, 32'd8);

    // Backpressure: output held, nothing granted.
    out_ready = 1'b0;
    #1;
    check("bp_ready0", {30'd0, req_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_data", out_data, 32'hFFFF8000);
      check("bp_id", {31'd0, out_id}, 32'd1);
      check("bp_ready", {30'd0, req_ready}, 32'd0);
    end
    check("bp_cnt", {16'd0, xfer_cnt}, 32'd8);

    // Release: drain and accept together.
    out_ready = 1'b1;
    #1;
    check("rel_ready", {30'd0, req_ready}, 32'd1);
    step();
    check("rel_valid", {31'd0, out_valid}, 32'd1);
    check("rel_data", out_data, 32'h00000001);
    check("rel_id", {31'd0, out_id}, 32'd0);
    check("rel_cnt", {16'd0, xfer_cnt}, 32'd9);

    // Asynchronous reset between edges with a pending output.
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_data", out_data, 32'd0);
    check("arst_cnt", {16'd0, xfer_cnt}, 32'd0);
    check("arst_ready", {30'd0, req_ready}, 32'd0);
    step();
    #2 rst_n = 1'b1;
    #1;
    check("post_rst_ready", {30'd0, req_ready}, 32'd1);
    step();
    check("post_rst_data", out_data, 32'h00000001);
    check("post_rst_id", {31'd0, out_id}, 32'd0);

    // Counter wrap: fresh reset, requester 0 streams continuously.
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    req_valid = 2'b01;
    step();
    check("wrap_start", {16'd0, xfer_cnt}, 32'd0);
    repeat (65535) step();
    check("wrap_ffff", {16'd0, xfer_cnt}, 32'h0000FFFF);
    step();
    check("wrap_zero", {16'd0, xfer_cnt}, 32'h00000000);
    check("wrap_valid", {31'd0, out_valid}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
